rvv_cmd_queue: RTL and testbench
================================

# rvv_cmd_queue

Multi-port circular command queue that sits directly downstream of the RVV front end. Each cycle it accepts up to N aligned RVVCmd entries and presents up to M in-order entries to the vector backend dispatch. It produces the `queue_capacity` value that the front end uses for instruction backpressure. That value is computed so that commands still in flight inside the front end's one-cycle register stage can never overflow the queue.

## Interface
- `N`, 4: enqueue width; matches the front end's N.
- `M`, 2: dequeue width.
- `DEPTH`, 16: entries; power of two, DEPTH ≥ 2*N.
- `CAPACITYBITS`, $clog2(2*N+1): capacity output width; matches the front end's input width.
- `clk`  in  1  clock; single clock domain.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `flush_i`  in  1  discard all queued and same-cycle enqueued commands.
- `enq_valid_i`  in  N  aligned enqueue valids (prefix of ones).
- `enq_data_i`  in  RVVCmd[N]  enqueue payloads.
- `capacity_o`  out  CAPACITYBITS  entries the upstream may accept this cycle.
- `deq_valid_o`  out  M  aligned dequeue valids.
- `deq_data_o`  out  RVVCmd[M]  oldest-first payloads; slot 0 is oldest.
- `deq_ready_i`  in  M  consumer ready per slot.
- `count_o`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage is DEPTH × RVVCmd. Registers `rd_ptr`/`wr_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH. `count_q` is $clog2(DEPTH+1) bits.
- Enqueue count `e` = popcount(enq_valid_i).
  - Entry i is written to slot (wr_ptr+i) mod DEPTH when i < min(e, free), where free = DEPTH − count_q.
  - Entries beyond `free` are dropped. This cannot occur with a compliant upstream.
  - A non-prefix `enq_valid_i` is illegal; RTL counts set bits only.
- Dequeue:
  - deq_valid_o[j] = (j < count_q).
  - deq_data_o[j] = mem[(rd_ptr+j) mod DEPTH].
  - Pop count `d` = length of the leading run of j with deq_valid_o[j] && deq_ready_i[j]. For example, ready 10 pops 0.
- Next state: count_q += e_accepted − d; wr_ptr += e_accepted; rd_ptr += d.
- Capacity: capacity_o = min(2*N, max(0, DEPTH − count_q − e)).
  - Same-cycle dequeue is deliberately excluded. This keeps the result conservative and removes any combinational path from `deq_ready_i`.
  - Commands accepted upstream at cycle t arrive at t+1, and at t+1 count_q ≤ count_q(t)+e(t). Therefore no overflow can occur.
- Flush:
  - Next cycle, count_q, rd_ptr and wr_ptr are all 0.
  - Same-cycle enqueue and dequeue are ignored; no pop is counted.
  - Memory contents are not cleared.
- Memory is not reset; only pointers, count and the optional stats registers are reset.

## Timing
- Enqueue-to-dequeue latency is 1 cycle. There is no same-cycle bypass: with the queue empty and e=2 at cycle t, deq_valid_o = 11 at t+1.
- capacity_o and count_o are combinational from registered state, plus `enq_valid_i` for capacity_o only.
- Reset values:
  - deq_valid_o = 0.
  - count_o = 0.
  - capacity_o = min(2*N, DEPTH) with no enqueue present (8 at defaults).
  - Pointers = 0.
- If reset asserts mid-operation, all state clears asynchronously and queued commands are lost.
- Full queue: deq_valid_o is all ones and capacity_o = 0.
- Empty queue: deq_valid_o = 0 and deq_data_o is don't-care.
- Simultaneous enqueue and dequeue at full: dequeued slots are not reusable in the same cycle.

## Configuration
- `RVV_CMD_QUEUE_STATS_EN` defined adds two outputs:
  - `max_occupancy_o` ($clog2(DEPTH+1)): high-water mark of count_q. Updated on the registered next count. Reset 0. Not cleared by flush.
  - `overflow_o` (1): sticky; set when e > free and flush_i=0. Reset 0.
- Undefined: both ports and their registers are absent. Excess enqueues are dropped silently.

## Test plan
- Reset, no stimulus -> capacity_o=8, deq_valid_o=00, count_o=0.
- Empty queue; enq 1111 with cmds A–D at t; ready 11 from t+1 -> capacity_o=8 at t; deq A,B at t+1; deq C,D at t+2; count_o 0 at t+3.
- Enq 1111 for 4 cycles, ready 00 -> count_o=16 and capacity_o=0. Then enq 0011 -> count stays 16, oldest entry unchanged, overflow_o=1 (STATS_EN).
- Enq 3 per cycle, ready 11 for 40 cycles -> output order exactly matches input sequence across ≥4 pointer wraps; no loss or duplication.
- count_o=2, ready 01 -> pops 1; ready 10 -> pops 0; ready 11 -> pops 2.
- count_o=5, flush_i with enq 1111 and ready 11 -> next cycle count_o=0, deq_valid_o=00, capacity_o=8; max_occupancy_o retains 5.

Source files
------------

// File: rtl/rvv_cmd_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : rvv_cmd_queue_if
// Description : Enqueue/dequeue bundle between the RVV front end, the
//               command queue and the vector backend dispatch.
//               slave  modport : the queue (accepts enqueues, presents
//                                dequeue slots, reports capacity)
//               master modport : the environment driving the queue
//   enq_valid_i  [N]        aligned enqueue valids (prefix of ones)
//   enq_data_i   [N]        enqueue payloads
//   capacity_o              entries upstream may accept this cycle
//   deq_valid_o  [M]        aligned dequeue valids
//   deq_data_o   [M]        oldest-first payloads, slot 0 oldest
//   deq_ready_i  [M]        consumer ready per slot
// Revision    : 1.0 - initial release
// ============================================================================
interface rvv_cmd_queue_if #(
  parameter int N            = 4,
  parameter int M            = 2,
  parameter int CMD_W        = 32,
  parameter int CAPACITYBITS = $clog2(2*N+1)
);
  logic [N-1:0]            enq_valid_i;
  logic [N-1:0][CMD_W-1:0] enq_data_i;
  logic [CAPACITYBITS-1:0] capacity_o;
  logic [M-1:0]            deq_valid_o;
  logic [M-1:0][CMD_W-1:0] deq_data_o;
  logic [M-1:0]            deq_ready_i;

  modport slave (
    input  enq_valid_i, enq_data_i, deq_ready_i,
    output capacity_o, deq_valid_o, deq_data_o
  );

  modport master (
    output enq_valid_i, enq_data_i, deq_ready_i,
    input  capacity_o, deq_valid_o, deq_data_o
  );
endinterface
`default_nettype wire

// File: rtl/rvv_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : rvv_cmd_queue
// Description : Multi-port circular RVV command queue. Accepts up to N
//               aligned commands per cycle, presents up to M oldest-first
//               commands to backend dispatch, and reports a conservative
//               capacity that covers commands still in the front end's
//               one-cycle register stage.
// Ports       : clk, rstn (async, active-low), flush_i,
//               q_if (rvv_cmd_queue_if.slave: enqueue, dequeue, capacity),
//               count_o (occupancy),
//               max_occupancy_o / overflow_o (only with STATS build)
// Config      : RVV_CMD_QUEUE_STATS_EN adds high-water mark and sticky
//               overflow outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module rvv_cmd_queue #(
  parameter int N            = 4,
  parameter int M            = 2,
  parameter int DEPTH        = 16,
  parameter int CMD_W        = 32,
  parameter int CAPACITYBITS = $clog2(2*N+1)
) (
  input  wire logic                       clk,
  input  wire logic                       rstn,
  input  wire logic                       flush_i,
  rvv_cmd_queue_if.slave                  q_if,
`ifdef RVV_CMD_QUEUE_STATS_EN
  output logic [$clog2(DEPTH+1)-1:0]      max_occupancy_o,
  output logic                            overflow_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0]      count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = $clog2(N+1);
  localparam int DW = $clog2(M+1);

  logic [CMD_W-1:0] mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic [EW-1:0] enq_cnt;
  logic [CW-1:0] free_cnt;
  logic [CW-1:0] enq_acc;
  logic [DW-1:0] pop_cnt;
  logic [CW:0]   used_cnt;
  logic [CW:0]   room_cnt;
  logic          pop_run;

  // Set bits are counted rather than trusting the prefix shape.
  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < N; i++) begin
      enq_cnt = enq_cnt + EW'(q_if.enq_valid_i[i]);
    end
  end

  assign free_cnt = CW'(DEPTH) - count_q;
  assign enq_acc  = (CW'(enq_cnt) > free_cnt) ? free_cnt : CW'(enq_cnt);

  genvar j;
  generate
    for (j = 0; j < M; j++) begin : g_deq
      assign q_if.deq_valid_o[j] = (CW'(j) < count_q);
      assign q_if.deq_data_o[j]  = mem_q[rd_ptr_q + PW'(j)];
    end
  endgenerate

  // Pops stop at the first slot that is not both valid and ready.
  always_comb begin
    pop_cnt = '0;
    pop_run = 1'b1;
    for (int k = 0; k < M; k++) begin
      if (pop_run && q_if.deq_valid_o[k] && q_if.deq_ready_i[k]) begin
        pop_cnt = pop_cnt + DW'(1);
      end else begin
        pop_run = 1'b0;
      end
    end
  end

  // Capacity ignores same-cycle pops so deq_ready_i never reaches it.
  always_comb begin
    used_cnt = {1'b0, count_q} + (CW+1)'(enq_cnt);
    if (used_cnt >= (CW+1)'(DEPTH)) begin
      room_cnt = '0;
    end else begin
      room_cnt = (CW+1)'(DEPTH) - used_cnt;
    end
    if (room_cnt > (CW+1)'(2*N)) begin
      room_cnt = (CW+1)'(2*N);
    end
  end

  assign q_if.capacity_o = CAPACITYBITS'(room_cnt);
  assign count_o         = count_q;

  always_comb begin
    count_d  = count_q + enq_acc - CW'(pop_cnt);
    wr_ptr_d = wr_ptr_q + PW'(enq_acc);
    rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
    if (flush_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately unreset; entry i lands at wr_ptr+i.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      for (int i = 0; i < N; i++) begin
        if (CW'(i) < enq_acc) begin
          mem_q[wr_ptr_q + PW'(i)] <= q_if.enq_data_i[i];
        end
      end
    end
  end

`ifdef RVV_CMD_QUEUE_STATS_EN
  logic [CW-1:0] max_occ_q, max_occ_d;
  logic          overflow_q, overflow_d;

  always_comb begin
    max_occ_d  = (count_d > max_occ_q) ? count_d : max_occ_q;
    overflow_d = overflow_q | (!flush_i && (CW'(enq_cnt) > free_cnt));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      max_occ_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      max_occ_q  <= max_occ_d;
      overflow_q <= overflow_d;
    end
  end

  assign max_occupancy_o = max_occ_q;
  assign overflow_o      = overflow_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvv_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvv_cmd_queue
// Description : Self-checking bench for rvv_cmd_queue. A queue-based model
//               predicts every output each cycle; directed literals pin the
//               model on the documented scenarios; random traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvv_cmd_queue;
  localparam int N = 4;
  localparam int M = 2;
  localparam int DEPTH = 16;
  localparam int CMD_W = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush_i = 1'b0;
  logic [4:0] count_o;
`ifdef RVV_CMD_QUEUE_STATS_EN
  logic [4:0] max_occupancy_o;
  logic       overflow_o;
`endif

  rvv_cmd_queue_if #(.N(N), .M(M), .CMD_W(CMD_W)) qif ();

  rvv_cmd_queue #(.N(N), .M(M), .DEPTH(DEPTH), .CMD_W(CMD_W)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .flush_i         (flush_i),
    .q_if            (qif),
`ifdef RVV_CMD_QUEUE_STATS_EN
    .max_occupancy_o (max_occupancy_o),
    .overflow_o      (overflow_o),
`endif
    .count_o         (count_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: contents oldest-first, plus stats.
  logic [31:0] mq [$];
  bit          ovf_m = 0;
  int          max_m = 0;
  logic [31:0] seq   = 32'h1000;

  // Last sampled outputs, for literal checks after a step.
  logic [31:0] cap_s, cnt_s, d0_s, d1_s;
  logic [1:0]  dv_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0][31:0] mk(input logic [31:0] base);
    logic [3:0][31:0] r;
    for (int i = 0; i < 4; i++) r[i] = base + 32'(i);
    return r;
  endfunction

  function automatic int model_cap(input int e);
    int c;
    c = DEPTH - mq.size() - e;
    if (c < 0) c = 0;
    if (c > 2*N) c = 2*N;
    return c;
  endfunction

  // Drive one cycle at the negedge, compare against the model, advance it.
  task automatic step(input bit fl, input int e, input logic [3:0][31:0] dat,
                      input logic [1:0] rdy);
    logic [3:0] v;
    int sz, d, free, acc;
    bit run;
    v = '0;
    for (int i = 0; i < e; i++) v[i] = 1'b1;
    flush_i         = fl;
    qif.enq_valid_i = v;
    qif.enq_data_i  = dat;
    qif.deq_ready_i = rdy;
    #1;
    sz = mq.size();
    cap_s = 32'(qif.capacity_o);
    cnt_s = 32'(count_o);
    dv_s  = qif.deq_valid_o;
    d0_s  = qif.deq_data_o[0];
    d1_s  = qif.deq_data_o[1];
    chk("capacity", cap_s, 32'(model_cap(e)));
    chk("count", cnt_s, 32'(sz));
    for (int j = 0; j < M; j++) begin
      chk("deq_valid", 32'(qif.deq_valid_o[j]), 32'(j < sz));
      if (j < sz) chk("deq_data", qif.deq_data_o[j], mq[j]);
    end
`ifdef RVV_CMD_QUEUE_STATS_EN
    chk("max_occupancy", 32'(max_occupancy_o), 32'(max_m));
    chk("overflow", 32'(overflow_o), 32'(ovf_m));
`endif
    d = 0;
    run = 1;
    for (int j = 0; j < M; j++) begin
      if (run && j < sz && rdy[j]) d++;
      else run = 0;
    end
    if (fl) begin
      mq.delete();
    end else begin
      free = DEPTH - sz;
      acc  = (e < free) ? e : free;
      if (e > free) ovf_m = 1;
      for (int j = 0; j < d; j++) void'(mq.pop_front());
      for (int i = 0; i < acc; i++) mq.push_back(dat[i]);
    end
    if (mq.size() > max_m) max_m = mq.size();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_data(output logic [3:0][31:0] dat);
    for (int i = 0; i < 4; i++) begin
      dat[i] = seq;
      seq = seq + 1;
    end
  endtask

  initial begin
    logic [3:0][31:0] dat;
    logic [31:0] oldest;
    int e;

    qif.enq_valid_i = '0;
    qif.enq_data_i  = '0;
    qif.deq_ready_i = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("reset_capacity", 32'(qif.capacity_o), 32'd8);
    chk("reset_deq_valid", 32'(qif.deq_valid_o), 32'd0);
    chk("reset_count", 32'(count_o), 32'd0);
    @(negedge clk);

    // A-D enqueue, then two-per-cycle drain.
    step(0, 4, mk(32'hA0), 2'b00);
    chk("ad_capacity_t", cap_s, 32'd8);
    step(0, 0, mk(0), 2'b11);
    chk("ad_valid_t1", 32'(dv_s), 32'd3);
    chk("ad_slot0_t1", d0_s, 32'hA0);
    chk("ad_slot1_t1", d1_s, 32'hA1);
    step(0, 0, mk(0), 2'b11);
    chk("ad_slot0_t2", d0_s, 32'hA2);
    chk("ad_slot1_t2", d1_s, 32'hA3);
    step(0, 0, mk(0), 2'b00);
    chk("ad_count_t3", cnt_s, 32'd0);

    // Fill to full, then push more into a full queue.
    for (int c = 0; c < 4; c++) step(0, 4, mk(32'hB0 + 32'(c*4)), 2'b00);
    step(0, 2, mk(32'hC0), 2'b00);
    chk("full_count", cnt_s, 32'd16);
    chk("full_capacity", cap_s, 32'd0);
    chk("full_valid", 32'(dv_s), 32'd3);
    step(0, 0, mk(0), 2'b00);
    chk("full_count_after", cnt_s, 32'd16);
    chk("full_oldest", d0_s, 32'hB0);
`ifdef RVV_CMD_QUEUE_STATS_EN
    chk("full_overflow", 32'(overflow_o), 32'd1);
`endif
    step(1, 0, mk(0), 2'b11);

    // Ready pattern pop counts at occupancy 2.
    step(0, 2, mk(32'hD0), 2'b00);
    step(0, 0, mk(0), 2'b01);
    chk("pop01_count", cnt_s, 32'd2);
    step(0, 1, mk(32'hD8), 2'b00);
    chk("pop01_after", cnt_s, 32'd1);
    step(0, 0, mk(0), 2'b10);
    chk("pop10_count", cnt_s, 32'd2);
    step(0, 0, mk(0), 2'b11);
    chk("pop10_after", cnt_s, 32'd2);
    step(0, 0, mk(0), 2'b00);
    chk("pop11_after", cnt_s, 32'd0);

    // Flush at occupancy 5 with enqueue and ready active.
    step(0, 4, mk(32'hE0), 2'b00);
    step(0, 1, mk(32'hE8), 2'b00);
    step(1, 4, mk(32'hF0), 2'b11);
    chk("flush_pre_count", cnt_s, 32'd5);
    step(0, 0, mk(0), 2'b00);
    chk("flush_count", cnt_s, 32'd0);
    chk("flush_valid", 32'(dv_s), 32'd0);
    chk("flush_capacity", cap_s, 32'd8);
`ifdef RVV_CMD_QUEUE_STATS_EN
    chk("flush_max_kept", 32'(max_occupancy_o), 32'd16);
`endif

    // Compliant streaming, three per cycle, across many pointer wraps.
    for (int c = 0; c < 40; c++) begin
      rand_data(dat);
      e = model_cap(0);
      if (e > 3) e = 3;
      step(0, e, dat, 2'b11);
    end

    // Unconstrained random traffic, including occasional flush.
    for (int c = 0; c < 400; c++) begin
      rand_data(dat);
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 4), dat,
           2'($urandom_range(0, 3)));
    end

    // Asynchronous reset mid-operation.
    for (int c = 0; c < 3; c++) begin
      rand_data(dat);
      step(0, 4, dat, 2'b00);
    end
    #2 rstn = 1'b0;
    #1;
    chk("async_reset_count", 32'(count_o), 32'd0);
    chk("async_reset_valid", 32'(qif.deq_valid_o), 32'd0);
    mq.delete();
    ovf_m = 0;
    max_m = 0;
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 60; c++) begin
      rand_data(dat);
      step(0, $urandom_range(0, 4), dat, 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1);
  end
endmodule
`default_nettype wire
